// File: rtl/smi_engine.sv
// smi_engine: Clause-22 style MDIO/SMI management frame engine.
// One 64-bit-period frame is run per request: 32-bit preamble, 14-bit header,
// two turnaround bits and 16 data bits. Frame state advances on the rising
// edge of clock; the MDIO driver and its enable change on the falling edge,
// so every driven bit is stable when the PHY samples it on the rising edge.
// Optional feature macro: SMI_TA_CHECK_EN adds a read turnaround check that
// reports a PHY that fails to pull the second turnaround bit low (ta_err).
module smi_engine (
   input  logic        clock,
   input  logic        rst,
   input  logic [4:0]  phy_addr,
   input  logic [4:0]  reg_addr,
   input  logic [15:0] data_i,
   output logic [15:0] data_o,
   input  logic        start,
   input  logic        rw,
   inout  wire         mdio,
   output logic        done,
   output logic        ta_err
);

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      HDR,
      TA,
      DATA,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  bitCnt_q, bitCnt_d;
   logic [4:0]  phyAddr_q, phyAddr_d;
   logic [4:0]  regAddr_q, regAddr_d;
   logic [15:0] wrData_q, wrData_d;
   logic        rw_q, rw_d;
   logic [15:0] shift_q, shift_d;
   logic [15:0] rdData_q, rdData_d;
   logic        mdioOut_q, mdioOut_d;
   logic        mdioOe_q, mdioOe_d;
   logic        mdioIn;
   logic [13:0] hdrWord;
   logic [3:0]  hdrIdx;
   logic [3:0]  dataIdx;

   // The line is only ever driven while the output enable is set; otherwise
   // the external pull-up (or the PHY) owns it.
   assign mdio   = mdioOe_q ? mdioOut_q : 1'bz;
   assign mdioIn = mdio;

   // Header word sent MSB first: ST=01, OP (01 write / 10 read), PHYAD, REGAD.
   assign hdrWord = {2'b01, (rw_q ? 2'b01 : 2'b10), phyAddr_q, regAddr_q};
   assign hdrIdx  = 4'd13 - bitCnt_q[3:0];
   assign dataIdx = 4'd15 - bitCnt_q[3:0];

   assign done   = (state_q == DONE);
   assign data_o = rdData_q;

   // Frame state register, bit counter, latched request and read shifter.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bitCnt_q  <= 6'd0;
         phyAddr_q <= 5'd0;
         regAddr_q <= 5'd0;
         wrData_q  <= 16'h0000;
         rw_q      <= 1'b0;
         shift_q   <= 16'h0000;
         rdData_q  <= 16'h0000;
      end else begin
         state_q   <= state_d;
         bitCnt_q  <= bitCnt_d;
         phyAddr_q <= phyAddr_d;
         regAddr_q <= regAddr_d;
         wrData_q  <= wrData_d;
         rw_q      <= rw_d;
         shift_q   <= shift_d;
         rdData_q  <= rdData_d;
      end
   end

   // Next-state logic: walk the frame phases, counting bits within each one.
   // DATA runs one extra count (16) as a released trailing period so that
   // done rises one edge after the last read bit has been sampled.
   always_comb begin
      state_d   = state_q;
      bitCnt_d  = bitCnt_q;
      phyAddr_d = phyAddr_q;
      regAddr_d = regAddr_q;
      wrData_d  = wrData_q;
      rw_d      = rw_q;
      shift_d   = shift_q;
      rdData_d  = rdData_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = PRE;
               bitCnt_d  = 6'd0;
               phyAddr_d = phy_addr;
               regAddr_d = reg_addr;
               wrData_d  = data_i;
               rw_d      = rw;
            end
         end
         PRE: begin
            if (bitCnt_q == 6'd31) begin
               state_d  = HDR;
               bitCnt_d = 6'd0;
            end else begin
               bitCnt_d = bitCnt_q + 6'd1;
            end
         end
         HDR: begin
            if (bitCnt_q == 6'd13) begin
               state_d  = TA;
               bitCnt_d = 6'd0;
            end else begin
               bitCnt_d = bitCnt_q + 6'd1;
            end
         end
         TA: begin
            if (bitCnt_q == 6'd1) begin
               state_d  = DATA;
               bitCnt_d = 6'd0;
            end else begin
               bitCnt_d = bitCnt_q + 6'd1;
            end
         end
         DATA: begin
            if (!rw_q && (bitCnt_q <= 6'd15)) begin
               shift_d = {shift_q[14:0], mdioIn};
            end
            if (bitCnt_q == 6'd16) begin
               state_d  = DONE;
               bitCnt_d = 6'd0;
               if (!rw_q) begin
                  rdData_d = shift_q;
               end
            end else begin
               bitCnt_d = bitCnt_q + 6'd1;
            end
         end
         DONE: begin
            if (!start) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d  = IDLE;
            bitCnt_d = 6'd0;
         end
      endcase
   end

   // Bit to present during the current period, decided from the frame state.
   always_comb begin
      mdioOe_d  = 1'b0;
      mdioOut_d = 1'b1;
      case (state_q)
         PRE: begin
            mdioOe_d  = 1'b1;
            mdioOut_d = 1'b1;
         end
         HDR: begin
            mdioOe_d  = 1'b1;
            mdioOut_d = hdrWord[hdrIdx];
         end
         TA: begin
            if (rw_q) begin
               mdioOe_d  = 1'b1;
               mdioOut_d = (bitCnt_q == 6'd0);
            end
         end
         DATA: begin
            if (rw_q && (bitCnt_q <= 6'd15)) begin
               mdioOe_d  = 1'b1;
               mdioOut_d = wrData_q[dataIdx];
            end
         end
         default: begin
            mdioOe_d  = 1'b0;
            mdioOut_d = 1'b1;
         end
      endcase
   end

   // MDIO driver updates on the falling edge; reset releases the line at once.
   always_ff @(negedge clock or posedge rst) begin
      if (rst) begin
         mdioOe_q  <= 1'b0;
         mdioOut_q <= 1'b1;
      end else begin
         mdioOe_q  <= mdioOe_d;
         mdioOut_q <= mdioOut_d;
      end
   end

`ifdef SMI_TA_CHECK_EN
   logic taBit_q, taBit_d;
   logic taErr_q, taErr_d;

   // Turnaround check: capture the second read turnaround bit, report it
   // when the frame completes and clear the flag when the next frame starts.
   always_comb begin
      taBit_d = taBit_q;
      taErr_d = taErr_q;
      if ((state_q == IDLE) && start) begin
         taErr_d = 1'b0;
      end
      if ((state_q == TA) && (bitCnt_q == 6'd1) && !rw_q) begin
         taBit_d = mdioIn;
      end
      if ((state_q == DATA) && (bitCnt_q == 6'd16) && !rw_q) begin
         taErr_d = taBit_q;
      end
   end

   // Turnaround check registers.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         taBit_q <= 1'b0;
         taErr_q <= 1'b0;
      end else begin
         taBit_q <= taBit_d;
         taErr_q <= taErr_d;
      end
   end

   assign ta_err = taErr_q;
`else
   assign ta_err = 1'b0;
`endif

endmodule
